// File: rtl/debounce_multi_pkg.sv
// Shared types and defaults for the multi-channel debouncer.
package debounce_multi_pkg;

   localparam int unsigned DEF_CH          = 4;
   localparam int unsigned DEF_N           = 22;
   localparam int unsigned DEF_SYNC_STAGES = 2;

   // Per-channel debounce FSM encoding; all four codes are legal.
   typedef enum logic [1:0] {
      ZERO  = 2'b00,
      WAIT0 = 2'b01,
      ONE   = 2'b10,
      WAIT1 = 2'b11
   } db_state_e;

endpackage : debounce_multi_pkg

// File: rtl/debounce_chan.sv
// One debounce channel: synchroniser, debounce FSM with window counter, level and edge ticks.
module debounce_chan
   import debounce_multi_pkg::*;
#(
   parameter int unsigned N           = DEF_N,
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic reset_n,
   input  logic tick_en,
   input  logic sw,
   output logic db_level,
   output logic rise_tick,
   output logic fall_tick,
   output logic tick_c
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   s;

   db_state_e              state_q, state_d;
   logic [N-1:0]           cnt_q, cnt_d;
   logic                   db_q, db_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;

   // Shift raw input through the synchroniser; only the last stage is trusted.
   assign sync_d = {sync_q[SYNC_STAGES-2:0], sw};
   assign s      = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q  <= '0;
         state_q <= ZERO;
         cnt_q   <= '0;
         db_q    <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         db_q    <= db_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   // Next state, counter, and registered-output next values.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      db_d    = 1'b0;
      rise_d  = 1'b0;
      fall_d  = 1'b0;

      case (state_q)
         ZERO: begin
            if (s) begin
               state_d = WAIT1;
               cnt_d   = '1;
            end
         end
         WAIT1: begin
            if (!s) begin
               state_d = ZERO;
            end else if (tick_en) begin
               cnt_d = cnt_q - N'(1);
               if (cnt_d == '0) state_d = ONE;
            end
         end
         ONE: begin
            if (!s) begin
               state_d = WAIT0;
               cnt_d   = '1;
            end
         end
         WAIT0: begin
            if (s) begin
               state_d = ONE;
            end else if (tick_en) begin
               cnt_d = cnt_q - N'(1);
               if (cnt_d == '0) state_d = ZERO;
            end
         end
         default: state_d = ZERO;
      endcase

      db_d   = (state_d == ONE) || (state_d == WAIT0);
      rise_d = (state_q == WAIT1) && (state_d == ONE);
      fall_d = (state_q == WAIT0) && (state_d == ZERO);
   end

   assign db_level  = db_q;
   assign rise_tick = rise_q;
   assign fall_tick = fall_q;
   assign tick_c    = rise_d | fall_d;

endmodule : debounce_chan

// File: rtl/debounce_multi.sv
// CH independent debounce channels with a shared tick_en prescale strobe and a merged tick flag.
module debounce_multi
   import debounce_multi_pkg::*;
#(
   parameter int unsigned CH          = DEF_CH,
   parameter int unsigned N           = DEF_N,
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          tick_en,
   input  logic [CH-1:0] sw,
   output logic [CH-1:0] db_level,
   output logic [CH-1:0] rise_tick,
   output logic [CH-1:0] fall_tick,
   output logic          any_tick
);

   logic [CH-1:0] tick_c;
   logic          any_tick_q;

   for (genvar i = 0; i < CH; i++) begin : g_chan
      debounce_chan #(
         .N           (N),
         .SYNC_STAGES (SYNC_STAGES)
      ) u_chan (
         .clk       (clk),
         .reset_n   (reset_n),
         .tick_en   (tick_en),
         .sw        (sw[i]),
         .db_level  (db_level[i]),
         .rise_tick (rise_tick[i]),
         .fall_tick (fall_tick[i]),
         .tick_c    (tick_c[i])
      );
   end

   // Registered from the channels' next-tick values so it aligns with the tick outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) any_tick_q <= 1'b0;
      else          any_tick_q <= |tick_c;
   end

   assign any_tick = any_tick_q;

endmodule : debounce_multi

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi with CH=4, N=4, SYNC_STAGES=2 (window 15 cycles).
module tb_debounce_multi;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       tick_en;
   logic [3:0] sw;
   logic [3:0] db_level;
   logic [3:0] rise_tick;
   logic [3:0] fall_tick;
   logic       any_tick;

   int n_assert = 0;
   int n_fail   = 0;

   debounce_multi #(
      .CH          (4),
      .N           (4),
      .SYNC_STAGES (2)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .tick_en   (tick_en),
      .sw        (sw),
      .db_level  (db_level),
      .rise_tick (rise_tick),
      .fall_tick (fall_tick),
      .any_tick  (any_tick)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [3:0] db, input logic [3:0] r,
                      input logic [3:0] f, input logic a);
      logic [12:0] obs;
      logic [12:0] expv;
      obs  = {db_level, rise_tick, fall_tick, any_tick};
      expv = {db, r, f, a};
      n_assert++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: db/rise/fall/any observed=%b expected=%b", tag, obs, expv);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      tick_en = 1'b1;
      sw      = 4'b0000;
      #1;
      chk("reset_state", 4'h0, 4'h0, 4'h0, 1'b0);
      step(); step();
      reset_n = 1'b1;

      // Idle run with a mid-cycle asynchronous reset.
      for (int i = 0; i < 40; i++) begin
         step();
         chk("idle_zero", 4'h0, 4'h0, 4'h0, 1'b0);
         if (i == 20) begin
            #3 reset_n = 1'b0;
            #1 chk("idle_async_reset", 4'h0, 4'h0, 4'h0, 1'b0);
            step();
            reset_n = 1'b1;
         end
      end

      // Channel 0 clean rise: 18th edge after drive.
      sw = 4'b0001;
      for (int i = 1; i <= 17; i++) begin
         step();
         chk("ch0_rise_wait", 4'h0, 4'h0, 4'h0, 1'b0);
      end
      step(); chk("ch0_rise_tick", 4'h1, 4'h1, 4'h0, 1'b1);
      step(); chk("ch0_rise_after", 4'h1, 4'h0, 4'h0, 1'b0);

      // Channel 1 bounce: 10 high, 1 low, then high again restarts the window.
      sw = 4'b0011;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("ch1_bounce_high", 4'h1, 4'h0, 4'h0, 1'b0);
      end
      sw = 4'b0001;
      step(); chk("ch1_bounce_low", 4'h1, 4'h0, 4'h0, 1'b0);
      sw = 4'b0011;
      for (int i = 1; i <= 17; i++) begin
         step();
         chk("ch1_restart_wait", 4'h1, 4'h0, 4'h0, 1'b0);
      end
      step(); chk("ch1_rise_tick", 4'h3, 4'h2, 4'h0, 1'b1);
      step(); chk("ch1_rise_after", 4'h3, 4'h0, 4'h0, 1'b0);

      // Channels 2 and 3 together, rise then fall.
      sw = 4'b1111;
      for (int i = 1; i <= 17; i++) begin
         step();
         chk("ch23_rise_wait", 4'h3, 4'h0, 4'h0, 1'b0);
      end
      step(); chk("ch23_rise_tick", 4'hF, 4'hC, 4'h0, 1'b1);
      step(); chk("ch23_rise_after", 4'hF, 4'h0, 4'h0, 1'b0);
      sw = 4'b0011;
      for (int i = 1; i <= 17; i++) begin
         step();
         chk("ch23_fall_wait", 4'hF, 4'h0, 4'h0, 1'b0);
      end
      step(); chk("ch23_fall_tick", 4'h3, 4'h0, 4'hC, 1'b1);
      step(); chk("ch23_fall_after", 4'h3, 4'h0, 4'h0, 1'b0);

      // Release channels 0 and 1.
      sw = 4'b0000;
      for (int i = 1; i <= 17; i++) begin
         step();
         chk("ch01_fall_wait", 4'h3, 4'h0, 4'h0, 1'b0);
      end
      step(); chk("ch01_fall_tick", 4'h0, 4'h0, 4'h3, 1'b1);
      step(); chk("ch01_fall_after", 4'h0, 4'h0, 4'h0, 1'b0);

      // tick_en held low: the window never completes.
      tick_en = 1'b0;
      sw      = 4'b0001;
      for (int i = 0; i < 60; i++) begin
         step();
         chk("tick_en_low_hold", 4'h0, 4'h0, 4'h0, 1'b0);
      end

      // tick_en every 4th cycle: 15 qualified edges finish the window.
      for (int p = 1; p <= 15; p++) begin
         tick_en = 1'b0;
         for (int i = 0; i < 3; i++) begin
            step();
            chk("tick_en_pulse_wait", 4'h0, 4'h0, 4'h0, 1'b0);
         end
         tick_en = 1'b1;
         step();
         if (p < 15) chk("tick_en_pulse_count", 4'h0, 4'h0, 4'h0, 1'b0);
         else        chk("tick_en_pulse_rise", 4'h1, 4'h1, 4'h0, 1'b1);
      end
      step(); chk("tick_en_pulse_after", 4'h1, 4'h0, 4'h0, 1'b0);

      // Reset while debounced high: no fall tick, then a fresh rise after release.
      step(); step();
      reset_n = 1'b0;
      #1 chk("mid_reset_async", 4'h0, 4'h0, 4'h0, 1'b0);
      step(); chk("mid_reset_held", 4'h0, 4'h0, 4'h0, 1'b0);
      reset_n = 1'b1;
      for (int i = 1; i <= 17; i++) begin
         step();
         chk("post_reset_wait", 4'h0, 4'h0, 4'h0, 1'b0);
      end
      step(); chk("post_reset_rise", 4'h1, 4'h1, 4'h0, 1'b1);
      step(); chk("post_reset_after", 4'h1, 4'h0, 4'h0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule : tb_debounce_multi
